// File: rtl/mac_layer_sequencer.sv
// Sequences a shared MAC through one fully connected layer, neuron by neuron:
// generates memory read addresses, drives the MAC issue flags, then adds the
// bias, applies ReLU/saturation and writes each neuron output.
module mac_layer_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int N_IN       = 4,
    parameter int N_OUT      = 3,
    parameter int MAC_LAT    = 1,
    parameter int FRAC_SHIFT = 0,
    parameter int RELU_EN    = 1,
    localparam int XW = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int WW = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    localparam int BW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    output logic                  busy,
    output logic                  done,
    output logic [XW-1:0]         x_addr,
    input  logic [DATA_WIDTH-1:0] x_data,
    output logic [WW-1:0]         w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [BW-1:0]         b_addr,
    input  logic [ACC_WIDTH-1:0]  b_data,
    output logic                  mac_start,
    output logic                  mac_valid,
    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_b,
    input  logic [ACC_WIDTH-1:0]  mac_result,
    output logic                  y_we,
    output logic [BW-1:0]         y_addr,
    output logic [OUT_WIDTH-1:0]  y_data
);

    localparam int CW = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

    localparam logic [XW-1:0] K_LAST = XW'(N_IN - 1);
    localparam logic [BW-1:0] J_LAST = BW'(N_OUT - 1);
    localparam logic [CW-1:0] D_LAST = CW'(MAC_LAT);

    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH + 1)'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = (ACC_WIDTH + 1)'(-(2 ** (OUT_WIDTH - 1)));

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [BW-1:0] j;
    logic [XW-1:0] k;
    logic [WW-1:0] w_ptr;
    logic [CW-1:0] dcnt;
    logic          issue_start;
    logic          issue_valid;

    logic signed [ACC_WIDTH:0] sum;
    logic signed [ACC_WIDTH:0] shifted;
    logic signed [ACC_WIDTH:0] clipped;
    logic [OUT_WIDTH-1:0]      y_val;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (go) state_next = S_FETCH;
            S_FETCH: if (k == K_LAST) state_next = S_DRAIN;
            S_DRAIN: if (dcnt == D_LAST) state_next = S_WRITE;
            S_WRITE: state_next = (j == J_LAST) ? S_DONE : S_FETCH;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Neuron/term counters; w_ptr walks j*N_IN+k incrementally so no multiplier is needed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j     <= '0;
            k     <= '0;
            w_ptr <= '0;
            dcnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        j     <= '0;
                        k     <= '0;
                        w_ptr <= '0;
                    end
                end
                S_FETCH: begin
                    dcnt <= '0;
                    if (k == K_LAST) begin
                        k <= '0;
                    end else begin
                        k     <= k + 1'b1;
                        w_ptr <= w_ptr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    dcnt <= dcnt + 1'b1;
                end
                S_WRITE: begin
                    k <= '0;
                    if (j != J_LAST) begin
                        j     <= j + 1'b1;
                        w_ptr <= w_ptr + 1'b1;
                    end
                end
                S_DONE: begin
                    j     <= '0;
                    w_ptr <= '0;
                end
                default: ;
            endcase
        end
    end

    // Issue flags delayed one cycle to line up with the synchronous memory read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_start <= 1'b0;
            issue_valid <= 1'b0;
        end else begin
            issue_start <= (state == S_FETCH) && (k == '0);
            issue_valid <= (state == S_FETCH) && (k != '0);
        end
    end

    // Bias add, scaling shift, optional ReLU and saturation to the output width
    always_comb begin
        sum = $signed({mac_result[ACC_WIDTH-1], mac_result})
            + $signed({b_data[ACC_WIDTH-1], b_data});
        shifted = sum >>> FRAC_SHIFT;
        clipped = shifted;
        if ((RELU_EN != 0) && shifted[ACC_WIDTH]) begin
            clipped = '0;
        end
        if (clipped > SAT_MAX) begin
            y_val = SAT_MAX[OUT_WIDTH-1:0];
        end else if (clipped < SAT_MIN) begin
            y_val = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            y_val = clipped[OUT_WIDTH-1:0];
        end
    end

    assign busy      = (state == S_FETCH) || (state == S_DRAIN) || (state == S_WRITE);
    assign done      = (state == S_DONE);
    assign x_addr    = k;
    assign w_addr    = w_ptr;
    assign b_addr    = j;
    assign mac_start = issue_start;
    assign mac_valid = issue_valid;
    assign mac_a     = x_data;
    assign mac_b     = w_data;
    assign y_we      = (state == S_WRITE);
    assign y_addr    = j;
    assign y_data    = (state == S_WRITE) ? y_val : '0;

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// Directed bench for mac_layer_sequencer: five parameterisations driven from
// local memories and simple MAC models, table-driven single-neuron vectors
// plus hand-written multi-neuron, mid-layer go and mid-layer reset sequences.
module tb_mac_layer_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- A (RELU on) and B (RELU off): N_IN=4, N_OUT=1 ----------------
    logic go_ab = 1'b0;
    logic signed [7:0]  xm_ab[0:3];
    logic signed [7:0]  wm_ab[0:3];
    logic signed [31:0] bm_ab[0:1];

    logic busy_a, done_a, ms_a, mv_a, we_a;
    logic [1:0] xa_a, wa_a;
    logic [0:0] ba_a, ya_a;
    logic signed [7:0]  xd_a, wd_a, ma_a, mb_a, yd_a;
    logic signed [31:0] bd_a, acc_a;

    logic busy_b, done_b, ms_b, mv_b, we_b;
    logic [1:0] xa_b, wa_b;
    logic [0:0] ba_b, ya_b;
    logic signed [7:0]  xd_b, wd_b, ma_b, mb_b, yd_b;
    logic signed [31:0] bd_b, acc_b;

    mac_layer_sequencer #(.DATA_WIDTH(8), .ACC_WIDTH(32), .OUT_WIDTH(8), .N_IN(4), .N_OUT(1),
                          .MAC_LAT(1), .FRAC_SHIFT(0), .RELU_EN(1)) u_a (
        .clk(clk), .rst_n(rst_n), .go(go_ab), .busy(busy_a), .done(done_a),
        .x_addr(xa_a), .x_data(xd_a), .w_addr(wa_a), .w_data(wd_a), .b_addr(ba_a), .b_data(bd_a),
        .mac_start(ms_a), .mac_valid(mv_a), .mac_a(ma_a), .mac_b(mb_a), .mac_result(acc_a),
        .y_we(we_a), .y_addr(ya_a), .y_data(yd_a));

    mac_layer_sequencer #(.DATA_WIDTH(8), .ACC_WIDTH(32), .OUT_WIDTH(8), .N_IN(4), .N_OUT(1),
                          .MAC_LAT(1), .FRAC_SHIFT(0), .RELU_EN(0)) u_b (
        .clk(clk), .rst_n(rst_n), .go(go_ab), .busy(busy_b), .done(done_b),
        .x_addr(xa_b), .x_data(xd_b), .w_addr(wa_b), .w_data(wd_b), .b_addr(ba_b), .b_data(bd_b),
        .mac_start(ms_b), .mac_valid(mv_b), .mac_a(ma_b), .mac_b(mb_b), .mac_result(acc_b),
        .y_we(we_b), .y_addr(ya_b), .y_data(yd_b));

    // ---------------- C: N_IN=4, N_OUT=3, RELU on ----------------
    logic go_c = 1'b0;
    logic signed [7:0]  xm_c[0:3];
    logic signed [7:0]  wm_c[0:15];
    logic signed [31:0] bm_c[0:3];

    logic busy_c, done_c, ms_c, mv_c, we_c;
    logic [1:0] xa_c, ba_c, ya_c;
    logic [3:0] wa_c;
    logic signed [7:0]  xd_c, wd_c, ma_c, mb_c, yd_c;
    logic signed [31:0] bd_c, acc_c;

    mac_layer_sequencer #(.DATA_WIDTH(8), .ACC_WIDTH(32), .OUT_WIDTH(8), .N_IN(4), .N_OUT(3),
                          .MAC_LAT(1), .FRAC_SHIFT(0), .RELU_EN(1)) u_c (
        .clk(clk), .rst_n(rst_n), .go(go_c), .busy(busy_c), .done(done_c),
        .x_addr(xa_c), .x_data(xd_c), .w_addr(wa_c), .w_data(wd_c), .b_addr(ba_c), .b_data(bd_c),
        .mac_start(ms_c), .mac_valid(mv_c), .mac_a(ma_c), .mac_b(mb_c), .mac_result(acc_c),
        .y_we(we_c), .y_addr(ya_c), .y_data(yd_c));

    // ---------------- D (RELU on) and E (RELU off): N_IN=1, N_OUT=1 ----------------
    logic go_de = 1'b0;
    logic signed [7:0]  xm_de[0:1];
    logic signed [7:0]  wm_de[0:1];
    logic signed [31:0] bm_de[0:1];

    logic busy_d, done_d, ms_d, mv_d, we_d;
    logic [0:0] xa_d, wa_d, ba_d, ya_d;
    logic signed [7:0]  xd_d, wd_d, ma_d, mb_d, yd_d;
    logic signed [31:0] bd_d, acc_d;

    logic busy_e, done_e, ms_e, mv_e, we_e;
    logic [0:0] xa_e, wa_e, ba_e, ya_e;
    logic signed [7:0]  xd_e, wd_e, ma_e, mb_e, yd_e;
    logic signed [31:0] bd_e, acc_e;

    mac_layer_sequencer #(.DATA_WIDTH(8), .ACC_WIDTH(32), .OUT_WIDTH(8), .N_IN(1), .N_OUT(1),
                          .MAC_LAT(1), .FRAC_SHIFT(0), .RELU_EN(1)) u_d (
        .clk(clk), .rst_n(rst_n), .go(go_de), .busy(busy_d), .done(done_d),
        .x_addr(xa_d), .x_data(xd_d), .w_addr(wa_d), .w_data(wd_d), .b_addr(ba_d), .b_data(bd_d),
        .mac_start(ms_d), .mac_valid(mv_d), .mac_a(ma_d), .mac_b(mb_d), .mac_result(acc_d),
        .y_we(we_d), .y_addr(ya_d), .y_data(yd_d));

    mac_layer_sequencer #(.DATA_WIDTH(8), .ACC_WIDTH(32), .OUT_WIDTH(8), .N_IN(1), .N_OUT(1),
                          .MAC_LAT(1), .FRAC_SHIFT(0), .RELU_EN(0)) u_e (
        .clk(clk), .rst_n(rst_n), .go(go_de), .busy(busy_e), .done(done_e),
        .x_addr(xa_e), .x_data(xd_e), .w_addr(wa_e), .w_data(wd_e), .b_addr(ba_e), .b_data(bd_e),
        .mac_start(ms_e), .mac_valid(mv_e), .mac_a(ma_e), .mac_b(mb_e), .mac_result(acc_e),
        .y_we(we_e), .y_addr(ya_e), .y_data(yd_e));

    // Synchronous-read memories (one cycle latency) and single-cycle MAC models
    always @(posedge clk) begin
        xd_a <= xm_ab[xa_a]; wd_a <= wm_ab[wa_a]; bd_a <= bm_ab[ba_a];
        xd_b <= xm_ab[xa_b]; wd_b <= wm_ab[wa_b]; bd_b <= bm_ab[ba_b];
        xd_c <= xm_c[xa_c];  wd_c <= wm_c[wa_c];  bd_c <= bm_c[ba_c];
        xd_d <= xm_de[xa_d]; wd_d <= wm_de[wa_d]; bd_d <= bm_de[ba_d];
        xd_e <= xm_de[xa_e]; wd_e <= wm_de[wa_e]; bd_e <= bm_de[ba_e];
        if (ms_a) acc_a <= ma_a * mb_a; else if (mv_a) acc_a <= acc_a + ma_a * mb_a;
        if (ms_b) acc_b <= ma_b * mb_b; else if (mv_b) acc_b <= acc_b + ma_b * mb_b;
        if (ms_c) acc_c <= ma_c * mb_c; else if (mv_c) acc_c <= acc_c + ma_c * mb_c;
        if (ms_d) acc_d <= ma_d * mb_d; else if (mv_d) acc_d <= acc_d + ma_d * mb_d;
        if (ms_e) acc_e <= ma_e * mb_e; else if (mv_e) acc_e <= acc_e + ma_e * mb_e;
    end

    typedef struct packed {
        logic [31:0] x;     // {x3,x2,x1,x0}
        logic [31:0] w;     // {w3,w2,w1,w0}
        logic [31:0] bias;
        logic [7:0]  y_relu;
        logic [7:0]  y_lin;
    } vec4_t;

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  w;
        logic [31:0] bias;
        logic [7:0]  y_relu;
        logic [7:0]  y_lin;
    } vec1_t;

    // One layer on A/B; expected done 8 cycles after the go cycle
    task automatic run_ab(input string tag, input int ya_exp, input int yb_exp);
        int g, starts, valids, overlap, busyc, dones, done_at, nwe_a, nwe_b, yaddr;
        int ya, yb;
        starts = 0; valids = 0; overlap = 0; busyc = 0; dones = 0; done_at = -1;
        nwe_a = 0; nwe_b = 0; yaddr = -1; ya = 999; yb = 999;
        @(negedge clk);
        go_ab = 1'b1;
        g = cyc;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            go_ab = 1'b0;
            if (ms_a) starts++;
            if (mv_a) valids++;
            if (ms_a && mv_a) overlap++;
            if (busy_a) busyc++;
            if (done_a) begin dones++; done_at = cyc; end
            if (we_a) begin nwe_a++; ya = int'(yd_a); yaddr = int'(ya_a); end
            if (we_b) begin nwe_b++; yb = int'(yd_b); end
        end
        check({tag, ".starts"}, starts, 1);
        check({tag, ".valids"}, valids, 3);
        check({tag, ".overlap"}, overlap, 0);
        check({tag, ".busy_cycles"}, busyc, 7);
        check({tag, ".done_pulses"}, dones, 1);
        check({tag, ".done_latency"}, done_at - g, 8);
        check({tag, ".we_a"}, nwe_a, 1);
        check({tag, ".y_addr_a"}, yaddr, 0);
        check({tag, ".y_relu"}, ya, ya_exp);
        check({tag, ".we_b"}, nwe_b, 1);
        check({tag, ".y_lin"}, yb, yb_exp);
    endtask

    // One layer on D/E (N_IN=1); expected done 5 cycles after the go cycle
    task automatic run_de(input string tag, input int yd_exp, input int ye_exp);
        int g, starts, valids, busyc, dones, done_at, nwe_d, nwe_e;
        int yd, ye;
        starts = 0; valids = 0; busyc = 0; dones = 0; done_at = -1;
        nwe_d = 0; nwe_e = 0; yd = 999; ye = 999;
        @(negedge clk);
        go_de = 1'b1;
        g = cyc;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            go_de = 1'b0;
            if (ms_d) starts++;
            if (mv_d || mv_e) valids++;
            if (busy_d) busyc++;
            if (done_d) begin dones++; done_at = cyc; end
            if (we_d) begin nwe_d++; yd = int'(yd_d); end
            if (we_e) begin nwe_e++; ye = int'(yd_e); end
        end
        check({tag, ".starts"}, starts, 1);
        check({tag, ".valids"}, valids, 0);
        check({tag, ".busy_cycles"}, busyc, 4);
        check({tag, ".done_pulses"}, dones, 1);
        check({tag, ".done_latency"}, done_at - g, 5);
        check({tag, ".we_d"}, nwe_d, 1);
        check({tag, ".y_relu"}, yd, yd_exp);
        check({tag, ".we_e"}, nwe_e, 1);
        check({tag, ".y_lin"}, ye, ye_exp);
    endtask

    // Full three-neuron layer on C, optionally with a stray go pulse mid-layer
    task automatic run_c(input string tag, input logic mid_go);
        int g, starts, valids, overlap, busyc, dones, done_at, nwe, issued;
        int prev_x, prev_w, prev_b;
        int ys[3];
        int yas[3];
        int exp_y[3];
        exp_y[0] = 10; exp_y[1] = 0; exp_y[2] = 127;
        starts = 0; valids = 0; overlap = 0; busyc = 0; dones = 0; done_at = -1;
        nwe = 0; issued = 0;
        for (int n = 0; n < 3; n++) begin ys[n] = 999; yas[n] = -1; end
        @(negedge clk);
        go_c = 1'b1;
        g = cyc;
        prev_x = int'(xa_c); prev_w = int'(wa_c); prev_b = int'(ba_c);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            go_c = mid_go && (i == 10);
            if (ms_c) starts++;
            if (mv_c) valids++;
            if (ms_c && mv_c) overlap++;
            if (ms_c || mv_c) begin
                check($sformatf("%s.w_addr%0d", tag, issued), prev_w, issued);
                check($sformatf("%s.x_addr%0d", tag, issued), prev_x, issued % 4);
                check($sformatf("%s.b_addr%0d", tag, issued), prev_b, issued / 4);
                issued++;
            end
            if (busy_c) busyc++;
            if (done_c) begin dones++; done_at = cyc; end
            if (we_c) begin
                if (nwe < 3) begin ys[nwe] = int'(yd_c); yas[nwe] = int'(ya_c); end
                nwe++;
            end
            prev_x = int'(xa_c); prev_w = int'(wa_c); prev_b = int'(ba_c);
        end
        check({tag, ".issued"}, issued, 12);
        check({tag, ".starts"}, starts, 3);
        check({tag, ".valids"}, valids, 9);
        check({tag, ".overlap"}, overlap, 0);
        check({tag, ".busy_cycles"}, busyc, 21);
        check({tag, ".done_pulses"}, dones, 1);
        check({tag, ".done_latency"}, done_at - g, 22);
        check({tag, ".we_count"}, nwe, 3);
        for (int n = 0; n < 3; n++) begin
            check($sformatf("%s.y_addr%0d", tag, n), yas[n], n);
            check($sformatf("%s.y_data%0d", tag, n), ys[n], exp_y[n]);
        end
    endtask

    function automatic logic [28:0] outs_c();
        return {busy_c, done_c, ms_c, mv_c, we_c, xa_c, wa_c, ba_c, ya_c, yd_c, 6'd0};
    endfunction

    function automatic logic [24:0] outs_a();
        return {busy_a, done_a, ms_a, mv_a, we_a, xa_a, wa_a, ba_a, ya_a, yd_a, 6'd0};
    endfunction

    initial begin
        vec4_t v4[4];
        vec1_t v1[3];
        int    we_seen;
        int    busy_seen;

        v4[0] = '{x: 32'h0104FF03, w: 32'h0AFE0502, bias: 32'd7,         y_relu: 8'd10,  y_lin: 8'd10};
        v4[1] = '{x: 32'h0104FF03, w: 32'h0AFE0502, bias: 32'hFFFFFFEC,  y_relu: 8'd0,   y_lin: 8'hEF};
        v4[2] = '{x: 32'h7F7F7F7F, w: 32'h0101017F, bias: 32'd0,         y_relu: 8'd127, y_lin: 8'd127};
        v4[3] = '{x: 32'h7F7F7F7F, w: 32'h01010181, bias: 32'd0,         y_relu: 8'd0,   y_lin: 8'h80};

        v1[0] = '{x: 8'hFB, w: 8'd6,   bias: 32'd2,  y_relu: 8'd0,   y_lin: 8'hE4};
        v1[1] = '{x: 8'd7,  w: 8'hFD,  bias: 32'd30, y_relu: 8'd9,   y_lin: 8'd9};
        v1[2] = '{x: 8'h80, w: 8'h80,  bias: 32'd0,  y_relu: 8'd127, y_lin: 8'd127};

        // Layer C contents: rows give 10, relu(-3)=0 and sat(150)=127
        xm_c[0] = 8'sd3; xm_c[1] = -8'sd1; xm_c[2] = 8'sd4; xm_c[3] = 8'sd1;
        for (int n = 0; n < 16; n++) wm_c[n] = 8'sd0;
        wm_c[0] = 8'sd2;  wm_c[1] = 8'sd5; wm_c[2]  = -8'sd2; wm_c[3]  = 8'sd10;
        wm_c[4] = 8'sd1;  wm_c[5] = 8'sd1; wm_c[6]  = 8'sd1;  wm_c[7]  = 8'sd1;
        wm_c[8] = 8'sd10; wm_c[9] = 8'sd0; wm_c[10] = 8'sd5;  wm_c[11] = 8'sd0;
        bm_c[0] = 32'sd7; bm_c[1] = -32'sd10; bm_c[2] = 32'sd100; bm_c[3] = 32'sd0;
        bm_ab[1] = 32'sd0;
        xm_de[1] = 8'sd0; wm_de[1] = 8'sd0; bm_de[1] = 32'sd0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.outs_a", outs_a(), 0);
        check("reset.outs_c", outs_c(), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 4; t++) begin
            for (int n = 0; n < 4; n++) begin
                xm_ab[n] = v4[t].x[8*n +: 8];
                wm_ab[n] = v4[t].w[8*n +: 8];
            end
            bm_ab[0] = v4[t].bias;
            run_ab($sformatf("n4v%0d", t), int'($signed(v4[t].y_relu)), int'($signed(v4[t].y_lin)));
        end

        for (int t = 0; t < 3; t++) begin
            xm_de[0] = v1[t].x;
            wm_de[0] = v1[t].w;
            bm_de[0] = v1[t].bias;
            run_de($sformatf("n1v%0d", t), int'($signed(v1[t].y_relu)), int'($signed(v1[t].y_lin)));
        end

        run_c("layer3", 1'b1);

        // Reset in the middle of neuron 1's fetch phase
        @(negedge clk);
        go_c = 1'b1;
        @(negedge clk);
        go_c = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst.busy_before", busy_c, 1);
        check("midrst.j_before", ba_c, 1);
        rst_n = 1'b0;
        #1;
        check("midrst.outs_now", outs_c(), 0);
        we_seen = 0;
        busy_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (we_c) we_seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (we_c) we_seen++;
            if (busy_c) busy_seen++;
        end
        check("midrst.no_writes", we_seen, 0);
        check("midrst.stays_idle", busy_seen, 0);

        run_c("after_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_layer_sequencer.md
Name: mac_layer_sequencer

Overview:
Sequences one shared `mac` instance (start/valid/a/b/result interface) to compute a fully connected MLP layer, one neuron at a time. It generates read addresses for the input-activation buffer, the weight memory and the bias memory, and drives the MAC's `start`/`valid`, `a` and `b`. It then adds the bias to the MAC result, applies optional ReLU and saturation, and writes each neuron output to the output buffer. Sits between the layer memories and the MAC datapath; started by the top-level MLP controller.

Parameters:
DATA_WIDTH, 8, signed width of activations and weights (MAC A_WIDTH = B_WIDTH).
ACC_WIDTH, 32, signed MAC accumulator width; also the bias width.
OUT_WIDTH, 8, signed output activation width.
N_IN, 4, inputs per neuron (>= 1).
N_OUT, 3, neurons in the layer (>= 1).
MAC_LAT, 1, cycles from the last term presented at the MAC to a valid `result`.
FRAC_SHIFT, 0, arithmetic right shift applied to (acc + bias) before saturation.
RELU_EN, 1, 1 = clamp negative results to 0.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
go  in  1  start a layer computation; sampled in IDLE only.
busy  out  1  high from the cycle after `go` is accepted until `done`.
done  out  1  one-cycle pulse at layer completion.
x_addr  out  clog2(N_IN)  input buffer read address.
x_data  in  DATA_WIDTH  input buffer read data, 1-cycle synchronous read.
w_addr  out  clog2(N_IN*N_OUT)  weight read address = j*N_IN + k.
w_data  in  DATA_WIDTH  weight read data, 1-cycle synchronous read.
b_addr  out  clog2(N_OUT)  bias read address = j.
b_data  in  ACC_WIDTH  bias read data, 1-cycle synchronous read.
mac_start  out  1  to MAC: load acc = a*b.
mac_valid  out  1  to MAC: acc += a*b.
mac_a  out  DATA_WIDTH  to MAC; equals x_data.
mac_b  out  DATA_WIDTH  to MAC; equals w_data.
mac_result  in  ACC_WIDTH  from MAC.
y_we  out  1  output buffer write enable.
y_addr  out  clog2(N_OUT)  output write address = j.
y_data  out  OUT_WIDTH  output value.

Behaviour:
- Reset (async, any state): state=IDLE; j=k=0; busy, done, mac_start, mac_valid and y_we = 0; all addresses and y_data = 0. A reset mid-layer abandons the layer with no further writes.
- FSM states: IDLE -> FETCH -> DRAIN -> WRITE -> (FETCH with j+1 | DONE) -> IDLE.
- IDLE: if go=1, then j=0, k=0, go to FETCH. go while not in IDLE is ignored.
- FETCH, N_IN cycles: each cycle drive x_addr=k, w_addr=j*N_IN+k, b_addr=j, then k++.
- MAC alignment: the issue flags are registered one cycle to match read latency.
  - mac_start=1 in the cycle after k=0 is issued.
  - mac_valid=1 in the cycles after k=1..N_IN-1 are issued.
  - mac_start and mac_valid are never both 1.
  - mac_a/mac_b pass x_data/w_data through.
- DRAIN: 1+MAC_LAT cycles covering the last term's read latency plus MAC latency. b_addr is held; b_data is stable by the end of DRAIN.
- WRITE, 1 cycle:
  - s = sign-extend(mac_result) + sign-extend(b_data), computed in ACC_WIDTH+1 bits with no overflow.
  - s = s >>> FRAC_SHIFT.
  - If RELU_EN and s<0, s=0.
  - Saturate s to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Assert y_we=1, y_addr=j, y_data=s.
  - If j==N_OUT-1, go to DONE; else j++, k=0, FETCH.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- Timing:
  - Cycles per neuron = N_IN+MAC_LAT+2.
  - `go` accepted at edge t0 -> first FETCH cycle is t0+1.
  - done is high in cycle t0+1+N_OUT*(N_IN+MAC_LAT+2).
- N_IN=1: only the mac_start pulse; mac_valid is never asserted.
- y_we is high exactly N_OUT cycles per layer, one per neuron, in ascending j.

Test Plan:
- N_IN=4, N_OUT=1; x=[3,-1,4,1], w=[2,5,-2,10], bias=7 -> acc=3, y_data=10 at y_addr 0. Check 1 start pulse and 3 valid pulses, done at t0+8.
- Same x/w, bias=-20, RELU_EN=1 -> y_data=0. With RELU_EN=0 -> y_data=-17.
- Saturation: x=[127,127,127,127], w=[127,1,1,1], bias=0 -> s=16510 -> y_data=127. Negate w[0] with RELU_EN=0 -> s=-15748 -> y_data=-128.
- N_OUT=3 with distinct weight rows -> three y_we pulses at y_addr 0,1,2 with correct values, w_addr sequence 0..11, single done pulse. A second go pulse mid-layer is ignored.
- Reset asserted mid-FETCH of neuron 1 -> all outputs 0 immediately and no further y_we. After release, go runs a full correct layer.
- N_IN=1, x=[-5], w=[6], bias=2 -> mac_valid never high, y_data=0 (RELU). With RELU_EN=0 -> -28.
